// File: rtl/alu_result_store.sv
// Result register behind the 8-bit ALU: debounced capture, two-deep history,
// low-nibble feedback to the ALU B operand and six active-low 7-seg digits.
module alu_result_store #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          BLANK_INVALID   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] alu_out,
  input  logic       load_req,
  input  logic       clear_hist,
  output logic [7:0] result,
  output logic [3:0] feedback_b,
  output logic [7:0] hist1,
  output logic [7:0] hist2,
  output logic [3:0] cap_count,
  output logic       captured,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  // state   | meaning
  // IDLE    | waiting for load_req to go high
  // PRESS   | load_req high, counting towards DEBOUNCE_CYCLES
  // CAPTURE | one cycle: shift history and store alu_out
  // RELEASE | waiting for load_req to stay low DEBOUNCE_CYCLES cycles
  typedef enum logic [1:0] {IDLE, PRESS, CAPTURE, RELEASE} state_t;

  localparam logic [15:0] DB_LIMIT = 16'(DEBOUNCE_CYCLES);
  localparam logic [6:0]  BLANK    = 7'b1111111;

  state_t      state, state_nxt;
  logic [15:0] db_cnt, db_cnt_nxt;
  logic        do_capture;
  logic [1:0]  hist_valid;

  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt;
    do_capture = 1'b0;
    case (state)
      IDLE: begin
        if (load_req) begin
          state_nxt  = PRESS;
          db_cnt_nxt = 16'd1;
        end
      end
      PRESS: begin
        if (!load_req) begin
          state_nxt  = IDLE;
          db_cnt_nxt = 16'd0;
        end else if (db_cnt >= DB_LIMIT) begin
          state_nxt = CAPTURE;
        end else begin
          db_cnt_nxt = db_cnt + 16'd1;
        end
      end
      CAPTURE: begin
        do_capture = 1'b1;
        state_nxt  = RELEASE;
        db_cnt_nxt = 16'd0;
      end
      RELEASE: begin
        // a bounce back high restarts the release window
        if (load_req) begin
          db_cnt_nxt = 16'd0;
        end else if (db_cnt >= DB_LIMIT) begin
          state_nxt  = IDLE;
          db_cnt_nxt = 16'd0;
        end else begin
          db_cnt_nxt = db_cnt + 16'd1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        db_cnt_nxt = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      db_cnt     <= 16'd0;
      captured   <= 1'b0;
      result     <= 8'd0;
      hist1      <= 8'd0;
      hist2      <= 8'd0;
      hist_valid <= 2'b00;
      cap_count  <= 4'd0;
    end else begin
      state    <= state_nxt;
      db_cnt   <= db_cnt_nxt;
      captured <= do_capture;
      if (do_capture) begin
        // capture takes priority over clear_hist for the shift of the old result
        result     <= alu_out;
        hist1      <= result;
        hist2      <= clear_hist ? 8'd0 : hist1;
        hist_valid <= clear_hist ? 2'b01 : {hist_valid[0], 1'b1};
        cap_count  <= cap_count + 4'd1;
      end else if (clear_hist) begin
        hist1      <= 8'd0;
        hist2      <= 8'd0;
        hist_valid <= 2'b00;
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  logic show_h1, show_h2;
  assign show_h1 = !BLANK_INVALID || hist_valid[0];
  assign show_h2 = !BLANK_INVALID || hist_valid[1];

  assign feedback_b = result[3:0];
  assign HEX0 = seg7(result[3:0]);
  assign HEX1 = seg7(result[7:4]);
  assign HEX2 = show_h1 ? seg7(hist1[3:0]) : BLANK;
  assign HEX3 = show_h1 ? seg7(hist1[7:4]) : BLANK;
  assign HEX4 = show_h2 ? seg7(hist2[3:0]) : BLANK;
  assign HEX5 = show_h2 ? seg7(hist2[7:4]) : BLANK;

endmodule
